// File: rtl/score_keeper.sv
// score_keeper
//   Single-clock match scoring stage between the ball datapath and the game
//   control FSM / HEX displays. Edge-detects the per-player point strobes,
//   ignores further points for a lockout window after each accepted point,
//   keeps saturating 4-bit scores, flags the match winner and drives two
//   active-low 7-segment digits.
//
// Optional feature macro: SCORE_WIN_BY_TWO_EN
//   defined   -> win needs score >= WIN_SCORE and a lead of 2 (lead of 1 at 15)
//   undefined -> first player whose score reaches WIN_SCORE wins
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous: zero scores, return to play
//   point_0    in   player 0 scored (level or pulse)
//   point_1    in   player 1 scored (level or pulse)
//   score_0    out  [3:0] player 0 score
//   score_1    out  [3:0] player 1 score
//   point_evt  out  one-cycle pulse per accepted point
//   match_over out  a winner exists
//   winner     out  0 = player 0, 1 = player 1 (valid while match_over)
//   hex_0      out  [6:0] active-low segments {g..a} for score_0
//   hex_1      out  [6:0] active-low segments {g..a} for score_1

module score_keeper #(
  parameter int WIN_SCORE      = 4,
  parameter int LOCKOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       point_0,
  input  logic       point_1,
  output logic [3:0] score_0,
  output logic [3:0] score_1,
  output logic       point_evt,
  output logic       match_over,
  output logic       winner,
  output logic [6:0] hex_0,
  output logic [6:0] hex_1
);

  localparam int         CW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    LOCKOUT = 2'd1,
    OVER    = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          p0_q, p1_q;
  logic [3:0]    score_0_n, score_1_n;
  logic          point_evt_n, match_over_n, winner_n;

  logic          rise_0, rise_1;
  logic [3:0]    inc_0, inc_1;
  logic          win_0, win_1;

  assign rise_0 = point_0 & ~p0_q;
  assign rise_1 = point_1 & ~p1_q;

  // Saturating increment: a score of 15 stays at 15.
  assign inc_0 = (score_0 == 4'hF) ? 4'hF : score_0 + 4'd1;
  assign inc_1 = (score_1 == 4'hF) ? 4'hF : score_1 + 4'd1;

`ifdef SCORE_WIN_BY_TWO_EN
  // Lead of two required, except a saturated 15 wins with any lead.
  assign win_0 = (inc_0 >= WIN) &&
                 (({1'b0, inc_0} >= {1'b0, score_1} + 5'd2) ||
                  ((inc_0 == 4'hF) && (inc_0 > score_1)));
  assign win_1 = (inc_1 >= WIN) &&
                 (({1'b0, inc_1} >= {1'b0, score_0} + 5'd2) ||
                  ((inc_1 == 4'hF) && (inc_1 > score_0)));
`else
  assign win_0 = (inc_0 == WIN);
  assign win_1 = (inc_1 == WIN);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PLAY;
      cnt        <= '0;
      p0_q       <= 1'b0;
      p1_q       <= 1'b0;
      score_0    <= '0;
      score_1    <= '0;
      point_evt  <= 1'b0;
      match_over <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      p0_q       <= point_0;
      p1_q       <= point_1;
      score_0    <= score_0_n;
      score_1    <= score_1_n;
      point_evt  <= point_evt_n;
      match_over <= match_over_n;
      winner     <= winner_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    score_0_n    = score_0;
    score_1_n    = score_1;
    point_evt_n  = 1'b0;
    match_over_n = match_over;
    winner_n     = winner;

    if (clear) begin
      state_n      = PLAY;
      cnt_n        = '0;
      score_0_n    = '0;
      score_1_n    = '0;
      match_over_n = 1'b0;
      winner_n     = 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          // Simultaneous rises cancel: neither player is awarded.
          if (rise_0 && !rise_1) begin
            point_evt_n = 1'b1;
            score_0_n   = inc_0;
            if (win_0) begin
              state_n      = OVER;
              match_over_n = 1'b1;
              winner_n     = 1'b0;
            end else begin
              state_n = LOCKOUT;
              cnt_n   = LOCK_LOAD;
            end
          end else if (rise_1 && !rise_0) begin
            point_evt_n = 1'b1;
            score_1_n   = inc_1;
            if (win_1) begin
              state_n      = OVER;
              match_over_n = 1'b1;
              winner_n     = 1'b1;
            end else begin
              state_n = LOCKOUT;
              cnt_n   = LOCK_LOAD;
            end
          end
        end
        LOCKOUT: begin
          // Return to PLAY the cycle after the counter reaches zero.
          if (cnt == '0) begin
            state_n = PLAY;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        OVER: begin
          state_n = OVER;
        end
        default: begin
          state_n = PLAY;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign hex_0 = seg7(score_0);
  assign hex_1 = seg7(score_1);

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Directed scoreboard bench for score_keeper with WIN_SCORE = 2 and
//   LOCKOUT_CYCLES = 16. Each step drives inputs on the falling edge, pushes
//   the expected post-edge outputs, then pops and compares them 1 time unit
//   after the rising edge. Expectations follow SCORE_WIN_BY_TWO_EN if defined.

module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       point_0 = 1'b0;
  logic       point_1 = 1'b0;
  logic [3:0] score_0, score_1;
  logic       point_evt, match_over, winner;
  logic [6:0] hex_0, hex_1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] s0;
    logic [3:0] s1;
    logic       evt;
    logic       mo;
    logic       win;
  } exp_t;

  exp_t sb[$];

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  score_keeper #(
    .WIN_SCORE      (2),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .point_0    (point_0),
    .point_1    (point_1),
    .score_0    (score_0),
    .score_1    (score_1),
    .point_evt  (point_evt),
    .match_over (match_over),
    .winner     (winner),
    .hex_0      (hex_0),
    .hex_1      (hex_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".score_0"},    {4'b0, score_0},    {4'b0, e.s0});
    check({tag, ".score_1"},    {4'b0, score_1},    {4'b0, e.s1});
    check({tag, ".point_evt"},  {7'b0, point_evt},  {7'b0, e.evt});
    check({tag, ".match_over"}, {7'b0, match_over}, {7'b0, e.mo});
    check({tag, ".winner"},     {7'b0, winner},     {7'b0, e.win});
    check({tag, ".hex_0"},      {1'b0, hex_0},      {1'b0, glyph[e.s0]});
    check({tag, ".hex_1"},      {1'b0, hex_1},      {1'b0, glyph[e.s1]});
  endtask

  // One clock step: drive, push expectation, clock, pop and compare.
  task automatic step(input string tag, input logic p0, input logic p1, input logic clr,
                      input logic [3:0] s0, input logic [3:0] s1,
                      input logic evt, input logic mo, input logic win);
    exp_t e;
    @(negedge clk);
    point_0 = p0;
    point_1 = p1;
    clear   = clr;
    e.s0 = s0; e.s1 = s1; e.evt = evt; e.mo = mo; e.win = win;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      check_all(tag, sb.pop_front());
    end
  endtask

  task automatic idle(input string tag, input int n, input logic p0, input logic p1,
                      input logic [3:0] s0, input logic [3:0] s1,
                      input logic mo, input logic win);
    for (int i = 0; i < n; i++) step(tag, p0, p1, 1'b0, s0, s1, 1'b0, mo, win);
  endtask

  initial begin
    exp_t z;
    z.s0 = 4'd0; z.s1 = 4'd0; z.evt = 1'b0; z.mo = 1'b0; z.win = 1'b0;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", z);
    @(negedge clk);
    reset = 1'b0;

    // Single pulse on point_0
    step("p0_pulse", 1, 0, 0, 1, 0, 1, 0, 0);
    step("p0_after", 0, 0, 0, 1, 0, 0, 0, 0);
    step("clear1",   0, 0, 1, 0, 0, 0, 0, 0);

    // point_1 held 5 cycles, re-rise at +10 (locked), rise at +17 (accepted, wins)
    step("p1_first", 0, 1, 0, 0, 1, 1, 0, 0);
    idle("p1_held", 4, 0, 1, 0, 1, 0, 0);
    idle("p1_low_a", 5, 0, 0, 0, 1, 0, 0);
    step("p1_locked", 0, 1, 0, 0, 1, 0, 0, 0);
    idle("p1_low_b", 6, 0, 0, 0, 1, 0, 0);
    step("p1_expiry", 0, 1, 0, 0, 2, 1, 1, 1);
    step("p1_over",   0, 0, 0, 0, 2, 0, 1, 1);
    step("clear2",    0, 0, 1, 0, 0, 0, 0, 0);

    // Two spaced point_0 rises win for player 0; then point_1 ignored
    step("w_p0a", 1, 0, 0, 1, 0, 1, 0, 0);
    idle("w_gap", 16, 0, 0, 1, 0, 0, 0);
    step("w_p0b", 1, 0, 0, 2, 0, 1, 1, 0);
    step("w_low", 0, 0, 0, 2, 0, 0, 1, 0);
    step("w_p1a", 0, 1, 0, 2, 0, 0, 1, 0);
    step("w_p1l", 0, 0, 0, 2, 0, 0, 1, 0);
    step("w_p1b", 0, 1, 0, 2, 0, 0, 1, 0);
    step("clear3", 0, 0, 1, 0, 0, 0, 0, 0);

    // Simultaneous rises cancel; clear beats a coincident point
    step("both",     1, 1, 0, 0, 0, 0, 0, 0);
    step("both_low", 0, 0, 0, 0, 0, 0, 0, 0);
    step("clr_pt",   0, 1, 1, 0, 0, 0, 0, 0);
    step("clr_low",  0, 0, 0, 0, 0, 0, 0, 0);
    step("post_clr", 0, 1, 0, 0, 1, 1, 0, 0);
    step("clear4",   0, 0, 1, 0, 0, 0, 0, 0);

    // P0, P1, P0, P0 with full lockout spacing
    step("s_p0a", 1, 0, 0, 1, 0, 1, 0, 0);
    idle("s_g1", 16, 0, 0, 1, 0, 0, 0);
    step("s_p1",  0, 1, 0, 1, 1, 1, 0, 0);
    idle("s_g2", 16, 0, 0, 1, 1, 0, 0);
`ifdef SCORE_WIN_BY_TWO_EN
    step("s_p0b", 1, 0, 0, 2, 1, 1, 0, 0);
    idle("s_g3", 16, 0, 0, 2, 1, 0, 0);
    step("s_p0c", 1, 0, 0, 3, 1, 1, 1, 0);
    step("s_end", 0, 0, 0, 3, 1, 0, 1, 0);
`else
    step("s_p0b", 1, 0, 0, 2, 1, 1, 1, 0);
    idle("s_g3", 16, 0, 0, 2, 1, 1, 0);
    step("s_p0c", 1, 0, 0, 2, 1, 0, 1, 0);
    step("s_end", 0, 0, 0, 2, 1, 0, 1, 0);
`endif
    step("clear5", 0, 0, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-lockout
    step("r_p0", 1, 0, 0, 1, 0, 1, 0, 0);
    idle("r_lock", 3, 0, 0, 1, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    check_all("async_reset", z);
    @(negedge clk);
    reset = 1'b0;
    step("r_first", 1, 0, 0, 1, 0, 1, 0, 0);
    // Held high across lockout expiry: no second point
    idle("r_held", 20, 1, 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
